// File: rtl/attn_pkg.sv
// Shared definitions for the attention line sender: time-step and
// attention widths, drain wait length and the scheduler state encoding.
package attn_pkg;

  localparam int TIME_STEPS        = 4;
  localparam int SYSTOLIC_UNIT_NUM = 16;
  localparam int ATTN_W            = $clog2(2 * SYSTOLIC_UNIT_NUM);
  localparam int WAIT_CYCLES       = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND   = 3'd1,
    WAIT   = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } attn_state_e;

  // Counter width that never collapses to zero bits for a count of one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/attn_line_addr_gen.sv
// Read sequencer for the attention / value-spike RAMs: walks col/line,
// produces the flat read address and flags the last beat and the first
// beat of line 1. With ATTN_SENDER_LINE_GAP_EN defined one idle cycle is
// inserted between consecutive lines.
module attn_line_addr_gen
  import attn_pkg::*;
#(
  parameter int LINE_LEN  = 64,
  parameter int NUM_LINES = 32,
  parameter int ADDR_W    = $clog2(LINE_LEN * NUM_LINES)
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              last_beat,
  output logic              first_beat_l1
);

  localparam int COL_W  = cnt_w(LINE_LEN);
  localparam int LINE_W = cnt_w(NUM_LINES);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_LEN - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(NUM_LINES - 1);

  logic              rd_en_q, rd_en_d;
  logic              gap_q, gap_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              col_end_s, line_end_s;

  assign col_end_s  = (col_q == COL_LAST);
  assign line_end_s = (line_q == LINE_LAST);

  // Next read position: linear address, col wraps into the next line.
  always_comb begin
    rd_en_d = rd_en_q;
    gap_d   = gap_q;
    col_d   = col_q;
    line_d  = line_q;
    addr_d  = addr_q;
    if (start) begin
      rd_en_d = 1'b1;
      gap_d   = 1'b0;
      col_d   = '0;
      line_d  = '0;
      addr_d  = '0;
    end else if (rd_en_q) begin
      if (col_end_s && line_end_s) begin
        rd_en_d = 1'b0;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
        if (col_end_s) begin
          col_d  = '0;
          line_d = line_q + LINE_W'(1);
`ifdef ATTN_SENDER_LINE_GAP_EN
          rd_en_d = 1'b0;
          gap_d   = 1'b1;
`else
          gap_d   = 1'b0;
`endif
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
    end else if (gap_q) begin
      rd_en_d = 1'b1;
      gap_d   = 1'b0;
    end else begin
      rd_en_d = 1'b0;
    end
  end

  // Sequencer registers.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      rd_en_q <= 1'b0;
      gap_q   <= 1'b0;
      col_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      rd_en_q <= rd_en_d;
      gap_q   <= gap_d;
      col_q   <= col_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
    end
  end

  assign rd_en         = rd_en_q;
  assign rd_addr       = addr_q;
  assign last_beat     = rd_en_q && col_end_s && line_end_s;
  assign first_beat_l1 = (NUM_LINES > 1) && rd_en_q &&
                         (line_q == LINE_W'(1)) && (col_q == '0);

endmodule

// File: rtl/attn_line_sender.sv
// Transmit scheduler feeding attention x value-spike beats into the line
// accumulator, then draining its line FIFO under sink backpressure.
// Optional build macro: ATTN_SENDER_LINE_GAP_EN (one bubble between lines).
module attn_line_sender
  import attn_pkg::*;
#(
  parameter int LINE_LEN  = 64,
  parameter int NUM_LINES = 32,
  parameter int ADDR_W    = $clog2(LINE_LEN * NUM_LINES),
  localparam int DW       = ATTN_W * TIME_STEPS,
  localparam int IDX_W    = cnt_w(LINE_LEN)
) (
  input  logic                  s_clk,
  input  logic                  s_rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_ram_rd_en,
  output logic [ADDR_W-1:0]     o_ram_rd_addr,
  input  logic [DW-1:0]         i_attn_rd_data,
  input  logic [TIME_STEPS-1:0] i_spike_rd_data,
  output logic                  o_SendData_valid,
  output logic [DW-1:0]         o_AttnRAM_data,
  output logic [TIME_STEPS-1:0] o_ValueSpikes,
  output logic                  o_FirstLine_done,
  output logic                  o_Finish_once,
  output logic                  o_finalMacData_valid,
  input  logic                  i_drain_ready,
  output logic [IDX_W-1:0]      o_drain_idx
);

  localparam int WAIT_W = cnt_w(WAIT_CYCLES + 1);
  // One cycle for the last beat to leave the payload register, then
  // the accumulator write pipeline and FIFO output latency.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(LINE_LEN - 1);

  attn_state_e           state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  valid_q, valid_d;
  logic                  fl_q, fl_d;
  logic [DW-1:0]         attn_q, attn_d;
  logic [TIME_STEPS-1:0] spike_q, spike_d;

  logic              accept_s, pop_s;
  logic              rd_en_s, last_beat_s, first_l1_s;
  logic [ADDR_W-1:0] rd_addr_s;

  assign accept_s = (state_q == IDLE) && i_start;
  assign pop_s    = (state_q == DRAIN) && i_drain_ready;

  attn_line_addr_gen #(
    .LINE_LEN  (LINE_LEN),
    .NUM_LINES (NUM_LINES),
    .ADDR_W    (ADDR_W)
  ) u_addr_gen (
    .s_clk         (s_clk),
    .s_rst         (s_rst),
    .start         (accept_s),
    .rd_en         (rd_en_s),
    .rd_addr       (rd_addr_s),
    .last_beat     (last_beat_s),
    .first_beat_l1 (first_l1_s)
  );

  // Run sequencing: send, settle, drain, finish.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        wait_d = '0;
        idx_d  = '0;
        if (accept_s) begin
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        wait_d = '0;
        if (last_beat_s) begin
          state_d = WAIT;
        end else begin
          state_d = SEND;
        end
      end
      WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = DRAIN;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      DRAIN: begin
        if (pop_s) begin
          if (idx_q == IDX_LAST) begin
            state_d = FINISH;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  // Payload stage: RAM data is captured on the edge after the read strobe
  // and held between beats; the line-1 marker rides along with it.
  always_comb begin
    valid_d = rd_en_s;
    fl_d    = first_l1_s;
    if (rd_en_s) begin
      attn_d  = i_attn_rd_data;
      spike_d = i_spike_rd_data;
    end else begin
      attn_d  = attn_q;
      spike_d = spike_q;
    end
  end

  // State and output registers.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      fl_q    <= 1'b0;
      attn_q  <= '0;
      spike_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      fl_q    <= fl_d;
      attn_q  <= attn_d;
      spike_q <= spike_d;
    end
  end

  assign o_busy               = busy_q;
  assign o_done               = done_q;
  assign o_Finish_once        = done_q;
  assign o_ram_rd_en          = rd_en_s;
  assign o_ram_rd_addr        = rd_addr_s;
  assign o_SendData_valid     = valid_q;
  assign o_AttnRAM_data       = attn_q;
  assign o_ValueSpikes        = spike_q;
  assign o_FirstLine_done     = fl_q;
  assign o_finalMacData_valid = pop_s;
  assign o_drain_idx          = idx_q;

endmodule

// File: tb/tb_attn_line_sender.sv
// Self-checking bench for attn_line_sender (LINE_LEN=4, NUM_LINES=3 and
// NUM_LINES=1). Expected beats and drained words are queued when a run is
// launched and compared as the DUT produces them. Honours
// ATTN_SENDER_LINE_GAP_EN when computing expected beat timing.
module tb_attn_line_sender;
  import attn_pkg::*;

  localparam int LL = 4;
  localparam int NL = 3;
  localparam int N  = LL * NL;
  localparam int DW = ATTN_W * TIME_STEPS;
`ifdef ATTN_SENDER_LINE_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  typedef struct { int cyc; int addr; logic [DW-1:0] attn; logic [TIME_STEPS-1:0] spk; } beat_t;
  typedef struct { int cyc; int idx; logic [47:0] word; } pop_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, ready, start1, ready1;
  logic busy, done, rd_en, valid, fl, fin, pop;
  logic [3:0] addr;
  logic [DW-1:0] attn_rd, attn;
  logic [TIME_STEPS-1:0] spk_rd, spk;
  logic [1:0] idx;
  logic busy1, done1, rd_en1, valid1, fl1, fin1, pop1;
  logic [1:0] addr1, idx1;
  logic [DW-1:0] attn_rd1, attn1;
  logic [TIME_STEPS-1:0] spk_rd1, spk1;

  logic [DW-1:0] attn_mem [16];
  logic [TIME_STEPS-1:0] spk_mem [16];
  logic [DW-1:0] attn1_mem [LL];
  logic [TIME_STEPS-1:0] spk1_mem [LL];

  beat_t sb_beat [$];
  pop_t  sb_pop [$];
  int n_checks = 0;
  int n_errors = 0;

  always_comb begin
    attn_rd  = attn_mem[addr];
    spk_rd   = spk_mem[addr];
    attn_rd1 = attn1_mem[addr1];
    spk_rd1  = spk1_mem[addr1];
  end

  attn_line_sender #(.LINE_LEN(LL), .NUM_LINES(NL)) dut (
    .s_clk(clk), .s_rst(rst), .i_start(start), .o_busy(busy), .o_done(done),
    .o_ram_rd_en(rd_en), .o_ram_rd_addr(addr), .i_attn_rd_data(attn_rd),
    .i_spike_rd_data(spk_rd), .o_SendData_valid(valid), .o_AttnRAM_data(attn),
    .o_ValueSpikes(spk), .o_FirstLine_done(fl), .o_Finish_once(fin),
    .o_finalMacData_valid(pop), .i_drain_ready(ready), .o_drain_idx(idx));

  attn_line_sender #(.LINE_LEN(LL), .NUM_LINES(1)) dut1 (
    .s_clk(clk), .s_rst(rst), .i_start(start1), .o_busy(busy1), .o_done(done1),
    .o_ram_rd_en(rd_en1), .o_ram_rd_addr(addr1), .i_attn_rd_data(attn_rd1),
    .i_spike_rd_data(spk_rd1), .o_SendData_valid(valid1), .o_AttnRAM_data(attn1),
    .o_ValueSpikes(spk1), .o_FirstLine_done(fl1), .o_Finish_once(fin1),
    .o_finalMacData_valid(pop1), .i_drain_ready(ready1), .o_drain_idx(idx1));

  // Reference accumulator: per time step, add attention where the spike is set.
  function automatic logic [47:0] mac_word(input logic [DW-1:0] a, input logic [TIME_STEPS-1:0] s,
                                           input logic [47:0] acc);
    logic [47:0] r;
    r = acc;
    for (int t = 0; t < TIME_STEPS; t++)
      if (s[t]) r[t*12 +: 12] = r[t*12 +: 12] + 12'(a[t*ATTN_W +: ATTN_W]);
    return r;
  endfunction

  function automatic int beat_cyc(input int k);
    return 2 + k + GAP * (k / LL);
  endfunction

  function automatic logic rdy_at(input int c, input int ds, input bit tog);
    if (!tog || c < ds) return 1'b1;
    return ((c - ds) % 4 == 0) || ((c - ds) % 4 == 3);
  endfunction

  task automatic run_scenario(input string tag, input bit tog, input bit poke, input int rst_at);
    int ds, done_c, c, n, rd_cnt, beat_n;
    logic [47:0] exp_acc [LL];
    logic [47:0] obs_acc [LL];
    beat_t b;
    pop_t p;
    sb_beat.delete();
    sb_pop.delete();
    for (int k = 0; k < N; k++) begin
      b.cyc = beat_cyc(k); b.addr = k; b.attn = attn_mem[k]; b.spk = spk_mem[k];
      sb_beat.push_back(b);
    end
    for (int col = 0; col < LL; col++) begin
      exp_acc[col] = '0;
      obs_acc[col] = '0;
      for (int l = 0; l < NL; l++)
        exp_acc[col] = mac_word(attn_mem[l*LL+col], spk_mem[l*LL+col], exp_acc[col]);
    end
    ds = beat_cyc(N - 1) + 4;
    c = ds; n = 0;
    while (n < LL) begin
      if (rdy_at(c, ds, tog)) begin
        p.cyc = c; p.idx = n; p.word = exp_acc[n];
        sb_pop.push_back(p);
        n++;
      end
      c++;
    end
    done_c = c;
    rd_cnt = 0; beat_n = 0;
    @(posedge clk); #1;
    start = 1'b1;
    ready = rdy_at(0, ds, tog);
    for (int cy = 0; cy <= done_c + 3; cy++) begin
      @(negedge clk);
      if (rst_at >= 0 && cy == rst_at + 1) begin
        n_checks++;
        if ({busy, done, rd_en, addr, valid, attn, spk, fl, fin, pop, idx} !== '0) begin
          n_errors++;
          $display("FAIL %s reset_clear cyc %0d: got busy=%b rd_en=%b valid=%b addr=%0d attn=%h idx=%0d, required all 0",
                   tag, cy, busy, rd_en, valid, addr, attn, idx);
        end
        break;
      end
      if (rd_en) begin
        n_checks++;
        if (rd_cnt >= N || int'(addr) != rd_cnt) begin
          n_errors++;
          $display("FAIL %s rd_addr cyc %0d: got %0d, required %0d", tag, cy, addr, rd_cnt);
        end
        rd_cnt++;
      end
      if (valid) begin
        n_checks++;
        if (sb_beat.size() == 0) begin
          n_errors++;
          $display("FAIL %s extra_beat cyc %0d: got valid, required none", tag, cy);
        end else begin
          b = sb_beat.pop_front();
          if (b.cyc != cy || attn !== b.attn || spk !== b.spk) begin
            n_errors++;
            $display("FAIL %s beat %0d: got cyc %0d attn %h spk %h, required cyc %0d attn %h spk %h",
                     tag, b.addr, cy, attn, spk, b.cyc, b.attn, b.spk);
          end
          obs_acc[beat_n % LL] = mac_word(attn, spk, obs_acc[beat_n % LL]);
          beat_n++;
        end
      end
      n_checks++;
      if (fl !== (cy == beat_cyc(LL))) begin
        n_errors++;
        $display("FAIL %s first_line cyc %0d: got %b, required %b", tag, cy, fl, cy == beat_cyc(LL));
      end
      if (pop) begin
        n_checks++;
        if (sb_pop.size() == 0) begin
          n_errors++;
          $display("FAIL %s extra_pop cyc %0d: got pop, required none", tag, cy);
        end else begin
          p = sb_pop.pop_front();
          if (p.cyc != cy || int'(idx) != p.idx || obs_acc[idx] !== p.word) begin
            n_errors++;
            $display("FAIL %s pop: got cyc %0d idx %0d word %h, required cyc %0d idx %0d word %h",
                     tag, cy, idx, obs_acc[idx], p.cyc, p.idx, p.word);
          end
        end
      end
      n_checks++;
      if (done !== (cy == done_c) || fin !== (cy == done_c)) begin
        n_errors++;
        $display("FAIL %s done cyc %0d: got done=%b fin=%b, required %b", tag, cy, done, fin, cy == done_c);
      end
      n_checks++;
      if (busy !== (cy >= 1 && cy <= done_c)) begin
        n_errors++;
        $display("FAIL %s busy cyc %0d: got %b, required %b", tag, cy, busy, cy >= 1 && cy <= done_c);
      end
      @(posedge clk); #1;
      start = poke && (cy + 1 == 5 || cy + 1 == done_c);
      ready = rdy_at(cy + 1, ds, tog);
      rst   = (rst_at >= 0 && cy + 1 == rst_at);
    end
    if (rst_at < 0) begin
      n_checks++;
      if (sb_beat.size() != 0 || sb_pop.size() != 0) begin
        n_errors++;
        $display("FAIL %s leftover: got %0d beats %0d pops outstanding, required 0 0",
                 tag, sb_beat.size(), sb_pop.size());
      end
    end
    start = 1'b0;
    ready = 1'b1;
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ready = 1'b1; start1 = 1'b0; ready1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, rd_en, addr, valid, attn, spk, fl, fin, pop, idx,
         busy1, done1, rd_en1, valid1, attn1, spk1, fl1, fin1, pop1, idx1} !== '0) begin
      n_errors++;
      $display("FAIL reset_values: got busy=%b rd_en=%b valid=%b attn=%h, required all 0", busy, rd_en, valid, attn);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    for (int k = 0; k < 16; k++) begin
      attn_mem[k] = DW'($urandom);
      spk_mem[k]  = TIME_STEPS'($urandom);
    end
    run_scenario("basic", 1'b0, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    run_scenario("backpressure", 1'b1, 1'b0, -1);
  endtask

  task automatic test_start_ignored();
    run_scenario("start_ignored", 1'b0, 1'b1, -1);
  endtask

  task automatic test_mid_reset();
    run_scenario("mid_reset", 1'b0, 1'b0, beat_cyc(5));
    repeat (2) @(posedge clk);
    run_scenario("rerun", 1'b0, 1'b0, -1);
  endtask

  task automatic test_accum();
    for (int k = 0; k < 16; k++) begin
      attn_mem[k] = {TIME_STEPS{5'd1}};
      spk_mem[k]  = 4'b1111;
    end
    run_scenario("accum", 1'b0, 1'b0, -1);
  endtask

  task automatic test_single_line();
    beat_t b;
    pop_t p;
    logic [47:0] acc [LL];
    int nb;
    sb_beat.delete();
    sb_pop.delete();
    nb = 0;
    for (int k = 0; k < LL; k++) begin
      attn1_mem[k] = DW'($urandom);
      spk1_mem[k]  = TIME_STEPS'($urandom);
      b.cyc = 2 + k; b.addr = k; b.attn = attn1_mem[k]; b.spk = spk1_mem[k];
      sb_beat.push_back(b);
      p.cyc = 9 + k; p.idx = k; p.word = mac_word(attn1_mem[k], spk1_mem[k], 48'd0);
      sb_pop.push_back(p);
      acc[k] = '0;
    end
    @(posedge clk); #1;
    start1 = 1'b1;
    for (int cy = 0; cy <= 16; cy++) begin
      @(negedge clk);
      if (valid1) begin
        n_checks++;
        if (sb_beat.size() == 0) begin
          n_errors++;
          $display("FAIL single extra_beat cyc %0d: got valid, required none", cy);
        end else begin
          b = sb_beat.pop_front();
          if (b.cyc != cy || attn1 !== b.attn || spk1 !== b.spk) begin
            n_errors++;
            $display("FAIL single beat %0d: got cyc %0d attn %h, required cyc %0d attn %h", b.addr, cy, attn1, b.cyc, b.attn);
          end
          acc[nb % LL] = mac_word(attn1, spk1, acc[nb % LL]);
          nb++;
        end
      end
      n_checks++;
      if (fl1 !== 1'b0) begin
        n_errors++;
        $display("FAIL single first_line cyc %0d: got %b, required 0", cy, fl1);
      end
      if (pop1) begin
        n_checks++;
        if (sb_pop.size() == 0) begin
          n_errors++;
          $display("FAIL single extra_pop cyc %0d: got pop, required none", cy);
        end else begin
          p = sb_pop.pop_front();
          if (p.cyc != cy || int'(idx1) != p.idx || acc[idx1] !== p.word) begin
            n_errors++;
            $display("FAIL single pop: got cyc %0d idx %0d word %h, required cyc %0d idx %0d word %h",
                     cy, idx1, acc[idx1], p.cyc, p.idx, p.word);
          end
        end
      end
      n_checks++;
      if (done1 !== (cy == 13) || fin1 !== (cy == 13)) begin
        n_errors++;
        $display("FAIL single done cyc %0d: got %b, required %b", cy, done1, cy == 13);
      end
      @(posedge clk); #1;
      start1 = 1'b0;
    end
    n_checks++;
    if (sb_beat.size() != 0 || sb_pop.size() != 0) begin
      n_errors++;
      $display("FAIL single leftover: got %0d beats %0d pops outstanding, required 0 0", sb_beat.size(), sb_pop.size());
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      attn_mem[k] = '0;
      spk_mem[k]  = '0;
    end
    for (int k = 0; k < LL; k++) begin
      attn1_mem[k] = '0;
      spk1_mem[k]  = '0;
    end
    test_reset();
    test_basic();
    test_backpressure();
    test_start_ignored();
    test_mid_reset();
    test_accum();
    test_single_line();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
